// File: rtl/tvip_axi_burst_address_generator.sv
// Expands one AXI address-channel command into a per-beat stream of address, strobe, index and last flag.
// Illegal commands are still expanded and marked with beat_error on every beat.
module tvip_axi_burst_address_generator #(
    parameter int ADDRESS_WIDTH = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ID_WIDTH-1:0]        cmd_id,
    input  logic [ADDRESS_WIDTH-1:0]   cmd_address,
    input  logic [7:0]                 cmd_burst_length,
    input  logic [2:0]                 cmd_burst_size,
    input  logic [1:0]                 cmd_burst_type,
    output logic                       beat_valid,
    input  logic                       beat_ready,
    output logic [ID_WIDTH-1:0]        beat_id,
    output logic [ADDRESS_WIDTH-1:0]   beat_address,
    output logic [DATA_WIDTH/8-1:0]    beat_strobe,
    output logic [7:0]                 beat_index,
    output logic                       beat_last,
    output logic                       beat_error
);
    localparam int BUS_BYTES = DATA_WIDTH / 8;

    localparam logic [1:0] TYPE_FIXED = 2'd0;
    localparam logic [1:0] TYPE_INCR  = 2'd1;
    localparam logic [1:0] TYPE_WRAP  = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK = ADDRESS_WIDTH'(BUS_BYTES - 1);

    function automatic logic [ADDRESS_WIDTH-1:0] size_mask(input logic [2:0] size);
        return (ADDRESS_WIDTH'(1) << size) - ADDRESS_WIDTH'(1);
    endfunction

    function automatic logic oversized(input logic [2:0] size);
        return (32'd1 << size) > 32'(BUS_BYTES);
    endfunction

    // Lanes from the beat address up to the end of its size-aligned container; all lanes if wider than the bus.
    function automatic logic [BUS_BYTES-1:0] lane_strobe(input logic [ADDRESS_WIDTH-1:0] addr,
                                                         input logic [2:0]               size);
        logic [ADDRESS_WIDTH-1:0] sm;
        logic [ADDRESS_WIDTH-1:0] lo;
        logic [ADDRESS_WIDTH-1:0] hi;
        logic [BUS_BYTES-1:0]     strb;
        sm = size_mask(size);
        lo = addr & LANE_MASK;
        hi = ((addr & ~sm) & LANE_MASK) + sm;
        for (int i = 0; i < BUS_BYTES; i++) begin
            strb[i] = (ADDRESS_WIDTH'(i) >= lo) && (ADDRESS_WIDTH'(i) <= hi);
        end
        if (oversized(size)) begin
            strb = '1;
        end
        return strb;
    endfunction

    logic [0:0]               state_q, state_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_BYTES-1:0]     strobe_q, strobe_d;
    logic [7:0]               index_q, index_d;
    logic                     last_q, last_d;
    logic                     err_q, err_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               type_q, type_d;
    logic [ADDRESS_WIDTH-1:0] wmask_q, wmask_d;

    logic                     beat_hs;
    logic                     cmd_accept;
    logic [ADDRESS_WIDTH-1:0] cmd_sm, cmd_aligned, cmd_span, cmd_end;
    logic                     wrap_len_ok;
    logic                     cmd_err;
    logic [1:0]               eff_type;
    logic [ADDRESS_WIDTH-1:0] beat_sm, next_addr;

    assign beat_hs    = (state_q == ST_BURST) && beat_ready;
    assign cmd_ready  = !areset && ((state_q == ST_IDLE) || (beat_hs && last_q));
    assign cmd_accept = cmd_valid && cmd_ready;

    // Legality check and effective burst type of the incoming command.
    always_comb begin
        cmd_sm      = size_mask(cmd_burst_size);
        cmd_aligned = cmd_address & ~cmd_sm;
        cmd_span    = ADDRESS_WIDTH'({1'b0, cmd_burst_length} + 9'd1) << cmd_burst_size;
        cmd_end     = cmd_aligned + cmd_span - ADDRESS_WIDTH'(1);
        wrap_len_ok = (cmd_burst_length == 8'd1) || (cmd_burst_length == 8'd3) ||
                      (cmd_burst_length == 8'd7) || (cmd_burst_length == 8'd15);
        eff_type    = cmd_burst_type;
        cmd_err     = oversized(cmd_burst_size);
        if (cmd_burst_type == 2'b11) begin
            eff_type = TYPE_FIXED;
            cmd_err  = 1'b1;
        end else if ((cmd_burst_type == TYPE_WRAP) &&
                     (!wrap_len_ok || ((cmd_address & cmd_sm) != '0))) begin
            eff_type = TYPE_INCR;
            cmd_err  = 1'b1;
        end
        if ((eff_type == TYPE_INCR) && ((cmd_end >> 12) != (cmd_address >> 12))) begin
            cmd_err = 1'b1;
        end
    end

    // Address of the beat following the current one.
    always_comb begin
        beat_sm = size_mask(size_q);
        case (type_q)
            TYPE_FIXED: next_addr = addr_q;
            TYPE_WRAP:  next_addr = (addr_q & ~wmask_q) |
                                    (((addr_q & ~beat_sm) + beat_sm + ADDRESS_WIDTH'(1)) & wmask_q);
            default:    next_addr = (addr_q & ~beat_sm) + beat_sm + ADDRESS_WIDTH'(1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        strobe_d = strobe_q;
        index_d  = index_q;
        last_d   = last_q;
        err_d    = err_q;
        len_d    = len_q;
        size_d   = size_q;
        type_d   = type_q;
        wmask_d  = wmask_q;
        if (cmd_accept) begin
            state_d  = ST_BURST;
            id_d     = cmd_id;
            addr_d   = cmd_address;
            strobe_d = lane_strobe(cmd_address, cmd_burst_size);
            index_d  = 8'd0;
            last_d   = (cmd_burst_length == 8'd0);
            err_d    = cmd_err;
            len_d    = cmd_burst_length;
            size_d   = cmd_burst_size;
            type_d   = eff_type;
            wmask_d  = cmd_span - ADDRESS_WIDTH'(1);
        end else if (beat_hs) begin
            if (last_q) begin
                state_d = ST_IDLE;
            end else begin
                addr_d   = next_addr;
                strobe_d = (type_q == TYPE_FIXED) ? strobe_q : lane_strobe(next_addr, size_q);
                index_d  = index_q + 8'd1;
                last_d   = ((index_q + 8'd1) == len_q);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            strobe_q <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            len_q    <= '0;
            size_q   <= '0;
            type_q   <= TYPE_FIXED;
            wmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
            index_q  <= index_d;
            last_q   <= last_d;
            err_q    <= err_d;
            len_q    <= len_d;
            size_q   <= size_d;
            type_q   <= type_d;
            wmask_q  <= wmask_d;
        end
    end

    assign beat_valid   = (state_q == ST_BURST);
    assign beat_id      = id_q;
    assign beat_address = addr_q;
    assign beat_strobe  = strobe_q;
    assign beat_index   = index_q;
    assign beat_last    = last_q;
    assign beat_error   = err_q;

endmodule

// File: tb/tb_tvip_axi_burst_address_generator.sv
// Directed bench for tvip_axi_burst_address_generator on a 32-bit and a 64-bit bus sharing one stimulus.
module tb_tvip_axi_burst_address_generator;
    localparam int AW = 64;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid;
    logic          beat_ready;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_address;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_type;

    logic r32, v32, l32, e32, r64, v64, l64, e64;
    logic [IW-1:0] id32, id64;
    logic [AW-1:0] a32, a64;
    logic [3:0]    s32;
    logic [7:0]    s64, i32, i64;

    tvip_axi_burst_address_generator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .ID_WIDTH(IW)) dut32 (
        .aclk(clk), .areset(rst), .cmd_valid(cmd_valid), .cmd_ready(r32), .cmd_id(cmd_id),
        .cmd_address(cmd_address), .cmd_burst_length(cmd_len), .cmd_burst_size(cmd_size),
        .cmd_burst_type(cmd_type), .beat_valid(v32), .beat_ready(beat_ready), .beat_id(id32),
        .beat_address(a32), .beat_strobe(s32), .beat_index(i32), .beat_last(l32), .beat_error(e32));

    tvip_axi_burst_address_generator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(64), .ID_WIDTH(IW)) dut64 (
        .aclk(clk), .areset(rst), .cmd_valid(cmd_valid), .cmd_ready(r64), .cmd_id(cmd_id),
        .cmd_address(cmd_address), .cmd_burst_length(cmd_len), .cmd_burst_size(cmd_size),
        .cmd_burst_type(cmd_type), .beat_valid(v64), .beat_ready(beat_ready), .beat_id(id64),
        .beat_address(a64), .beat_strobe(s64), .beat_index(i64), .beat_last(l64), .beat_error(e64));

    logic          use32;
    logic          o_ready, o_valid, o_last, o_err;
    logic [IW-1:0] o_id;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_strb, o_idx;

    always_comb begin
        o_ready = use32 ? r32 : r64;
        o_valid = use32 ? v32 : v64;
        o_last  = use32 ? l32 : l64;
        o_err   = use32 ? e32 : e64;
        o_id    = use32 ? id32 : id64;
        o_addr  = use32 ? a32 : a64;
        o_strb  = use32 ? {4'b0000, s32} : s64;
        o_idx   = use32 ? i32 : i64;
    end

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [90:0] pk(input logic v, input logic [63:0] a, input logic [7:0] s,
                                       input logic [7:0] i, input logic l, input logic e,
                                       input logic [7:0] id);
        return {v, a, s, i, l, e, id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] btype);
        int w;
        cmd_id = id; cmd_address = addr; cmd_len = len; cmd_size = size; cmd_type = btype;
        cmd_valid = 1'b1;
        #1;
        w = 0;
        while (!o_ready && w < 20) begin
            step();
            w++;
        end
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 20 cycles", o_ready);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0; use32 = 1'b0;
        cmd_id = '0; cmd_address = '0; cmd_len = '0; cmd_size = '0; cmd_type = '0;
        step(); step();
        n_cmp++;
        if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required %h",
                     pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(0, 0, 0, 0, 0, 0, 0));
        end
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cmd_ready: got %b, required 0", o_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_cmd_ready: got %b, required 1", o_ready);
        end
    endtask

    task automatic test_incr();
        logic [63:0] ea [4] = '{64'h1003, 64'h1004, 64'h1008, 64'h100C};
        logic [7:0]  es [4] = '{8'h08, 8'h0F, 8'h0F, 8'h0F};
        use32 = 1'b1; beat_ready = 1'b1;
        send_cmd(8'h11, 64'h1003, 8'd3, 3'd2, 2'd1);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, ea[k], es[k], 8'(k), k == 3, 0, 8'h11)) begin
                n_bad++;
                $display("FAIL incr_beat%0d: got %h, required %h", k,
                         pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, ea[k], es[k], 8'(k), k == 3, 0, 8'h11));
            end
            step();
        end
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL incr_end_valid: got %b, required 0", o_valid);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] ea [4] = '{64'h38, 64'h20, 64'h28, 64'h30};
        use32 = 1'b0; beat_ready = 1'b1;
        send_cmd(8'h5A, 64'h38, 8'd3, 3'd3, 2'd2);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, ea[k], 8'hFF, 8'(k), k == 3, 0, 8'h5A)) begin
                n_bad++;
                $display("FAIL wrap_beat%0d: got %h, required %h", k,
                         pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, ea[k], 8'hFF, 8'(k), k == 3, 0, 8'h5A));
            end
            step();
        end
    endtask

    task automatic test_fixed();
        use32 = 1'b1; beat_ready = 1'b1;
        send_cmd(8'h07, 64'h102, 8'd1, 3'd1, 2'd0);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, 64'h102, 8'h0C, 8'(k), k == 1, 0, 8'h07)) begin
                n_bad++;
                $display("FAIL fixed_beat%0d: got %h, required %h", k,
                         pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, 64'h102, 8'h0C, 8'(k), k == 1, 0, 8'h07));
            end
            step();
        end
    endtask

    task automatic test_errors();
        // oversize INCR, WRAP of 3 beats, INCR crossing 4KB, reserved type, unaligned WRAP
        int unsigned caddr [5] = '{32'h0, 32'h0, 32'hFF8, 32'h105, 32'h3A};
        logic [7:0]  clen  [5] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
        logic [2:0]  csize [5] = '{3'd4, 3'd2, 3'd3, 3'd0, 3'd3};
        logic [1:0]  ctype [5] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd2};
        int unsigned ea [5][4] = '{'{32'h0, 32'h10, 0, 0}, '{32'h0, 32'h4, 32'h8, 0},
                                   '{32'hFF8, 32'h1000, 0, 0}, '{32'h105, 32'h105, 32'h105, 0},
                                   '{32'h3A, 32'h40, 32'h48, 32'h50}};
        logic [7:0]  es [5][4] = '{'{8'hFF, 8'hFF, 0, 0}, '{8'h0F, 8'hF0, 8'h0F, 0},
                                   '{8'hFF, 8'hFF, 0, 0}, '{8'h20, 8'h20, 8'h20, 0},
                                   '{8'hFC, 8'hFF, 8'hFF, 8'hFF}};
        use32 = 1'b0; beat_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            send_cmd(8'(8'h80 + c), 64'(caddr[c]), clen[c], csize[c], ctype[c]);
            for (int k = 0; k <= int'(clen[c]); k++) begin
                n_cmp++;
                if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !==
                    pk(1, 64'(ea[c][k]), es[c][k], 8'(k), k == int'(clen[c]), 1, 8'(8'h80 + c))) begin
                    n_bad++;
                    $display("FAIL error_case%0d_beat%0d: got %h, required %h", c, k,
                             pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id),
                             pk(1, 64'(ea[c][k]), es[c][k], 8'(k), k == int'(clen[c]), 1, 8'(8'h80 + c)));
                end
                step();
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ea [4] = '{64'h1003, 64'h1004, 64'h1008, 64'h100C};
        logic [7:0]  es [4] = '{8'h08, 8'h0F, 8'h0F, 8'h0F};
        use32 = 1'b1; beat_ready = 1'b1;
        send_cmd(8'h22, 64'h1003, 8'd3, 3'd2, 2'd1);
        step();
        beat_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            n_cmp++;
            if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, ea[1], es[1], 8'd1, 0, 0, 8'h22)) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got %h, required %h", h,
                         pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, ea[1], es[1], 8'd1, 0, 0, 8'h22));
            end
            step();
        end
        beat_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, ea[k], es[k], 8'(k), k == 3, 0, 8'h22)) begin
                n_bad++;
                $display("FAIL stall_beat%0d: got %h, required %h", k,
                         pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, ea[k], es[k], 8'(k), k == 3, 0, 8'h22));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        use32 = 1'b0; beat_ready = 1'b1;
        send_cmd(8'h33, 64'h100, 8'd1, 3'd3, 2'd1);
        n_cmp++;
        if (o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ready_midburst: got %b, required 0", o_ready);
        end
        step();
        cmd_id = 8'h44; cmd_address = 64'h200; cmd_len = 8'd0; cmd_size = 3'd3; cmd_type = 2'd1;
        cmd_valid = 1'b1;
        #1;
        n_cmp++;
        if (o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready_on_last: got %b, required 1", o_ready);
        end
        n_cmp++;
        if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, 64'h108, 8'hFF, 8'd1, 1, 0, 8'h33)) begin
            n_bad++;
            $display("FAIL b2b_first_last: got %h, required %h",
                     pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, 64'h108, 8'hFF, 8'd1, 1, 0, 8'h33));
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, 64'h200, 8'hFF, 8'd0, 1, 0, 8'h44)) begin
            n_bad++;
            $display("FAIL b2b_second_beat0: got %h, required %h",
                     pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, 64'h200, 8'hFF, 8'd0, 1, 0, 8'h44));
        end
        step();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end_valid: got %b, required 0", o_valid);
        end
    endtask

    task automatic test_reset_midburst();
        use32 = 1'b0; beat_ready = 1'b1;
        send_cmd(8'h66, 64'h0, 8'd7, 3'd3, 2'd1);
        step(); step();
        n_cmp++;
        if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, 64'h10, 8'hFF, 8'd2, 0, 0, 8'h66)) begin
            n_bad++;
            $display("FAIL rst_mid_beat2: got %h, required %h",
                     pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, 64'h10, 8'hFF, 8'd2, 0, 0, 8'h66));
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({o_valid, o_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_abandon: valid,ready=%b, required 00", {o_valid, o_ready});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL rst_mid_release: valid,ready=%b, required 01", {o_valid, o_ready});
        end
        send_cmd(8'h77, 64'h40, 8'd1, 3'd3, 2'd1);
        n_cmp++;
        if (pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id) !== pk(1, 64'h40, 8'hFF, 8'd0, 0, 0, 8'h77)) begin
            n_bad++;
            $display("FAIL rst_mid_newburst: got %h, required %h",
                     pk(o_valid, o_addr, o_strb, o_idx, o_last, o_err, o_id), pk(1, 64'h40, 8'hFF, 8'd0, 0, 0, 8'h77));
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
